// File: rtl/cap_pad_model.sv
// rtl/cap_pad_model.sv - capacitive touch pad model: discharge, RC charge-up and touch delay.
// Optional charge jitter LFSR enabled by defining CAP_PAD_MODEL_NOISE_EN.
module cap_pad_model #(
  parameter int CNT_W      = 16,
  parameter int BASE_DELAY = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             drive_out,
  input  logic             drive_oe,
  input  logic             touch,
  input  logic [CNT_W-1:0] touch_extra,
  output logic             pad_level,
  output logic             charge_done,
  output logic [CNT_W-1:0] charge_cycles,
  output logic [1:0]       pad_state
);

  typedef enum logic [1:0] {
    DRIVE_LO = 2'd0,
    CHARGING = 2'd1,
    CHARGED  = 2'd2,
    DRIVE_HI = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_thr;
  logic             r_pad;
  logic             r_done;
  logic [CNT_W-1:0] r_cyc;

  state_t           w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [CNT_W-1:0] w_thr_nx;
  logic             w_pad_nx;
  logic             w_done_nx;
  logic [CNT_W-1:0] w_cyc_nx;

  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_sum_sat;
  logic [CNT_W-1:0] w_thr_calc;

  // Base plus touch delay, computed one bit wider so it can saturate instead of wrap.
  assign w_sum     = (CNT_W+1)'(BASE_DELAY) + (touch ? {1'b0, touch_extra} : '0);
  assign w_sum_sat = w_sum[CNT_W] ? CNT_MAX : w_sum[CNT_W-1:0];

`ifdef CAP_PAD_MODEL_NOISE_EN
  logic [7:0]       r_lfsr;
  logic [CNT_W:0]   w_noisy;
  logic [CNT_W-1:0] w_noisy_sat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_noisy     = {1'b0, w_sum_sat} + (CNT_W+1)'(r_lfsr[1:0]);
  assign w_noisy_sat = w_noisy[CNT_W] ? CNT_MAX : w_noisy[CNT_W-1:0];
  assign w_thr_calc  = (w_noisy_sat == '0) ? CNT_W'(1) : w_noisy_sat;
`else
  assign w_thr_calc  = (w_sum_sat == '0) ? CNT_W'(1) : w_sum_sat;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_thr_nx   = r_thr;
    w_pad_nx   = r_pad;
    w_done_nx  = 1'b0;
    w_cyc_nx   = r_cyc;
    if (drive_oe) begin
      if (drive_out) begin
        w_state_nx = DRIVE_HI;
        w_pad_nx   = 1'b1;
      end else begin
        w_state_nx = DRIVE_LO;
        w_cnt_nx   = '0;
        w_pad_nx   = 1'b0;
      end
    end else begin
      case (r_state)
        DRIVE_LO: begin
          w_state_nx = CHARGING;
          w_cnt_nx   = CNT_W'(1);
          w_thr_nx   = w_thr_calc;
          w_pad_nx   = 1'b0;
        end
        CHARGING: begin
          if (r_cnt == r_thr) begin
            w_state_nx = CHARGED;
            w_pad_nx   = 1'b1;
            w_done_nx  = 1'b1;
            w_cyc_nx   = r_cnt;
          end else if (r_cnt != CNT_MAX) begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end
        CHARGED: begin
          w_pad_nx = 1'b1;
        end
        DRIVE_HI: begin
          // Pad was held high, so it is already charged: no pulse, count untouched.
          w_state_nx = CHARGED;
          w_pad_nx   = 1'b1;
        end
        default: begin
          w_state_nx = DRIVE_LO;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= DRIVE_LO;
      r_cnt   <= '0;
      r_thr   <= '0;
      r_pad   <= 1'b0;
      r_done  <= 1'b0;
      r_cyc   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_thr   <= w_thr_nx;
      r_pad   <= w_pad_nx;
      r_done  <= w_done_nx;
      r_cyc   <= w_cyc_nx;
    end
  end

  assign pad_level     = r_pad;
  assign charge_done   = r_done;
  assign charge_cycles = r_cyc;
  assign pad_state     = r_state;

endmodule

// File: doc/cap_pad_model.md
Name: cap_pad_model

Overview:
- Behavioural model of a capacitive touch pad, built as synthesizable RTL.
- Connects to the pad side of the capacitive-touch sensor: it sees the sensor's drive value and output enable, and returns the pad logic level the sensor samples on its input.
- Used for on-chip self-test and loopback mode. It lets the sensor's charge-time measurement and button decision run without an external pad.
- Emulates discharge when driven, RC charge-up when released, and extra charge time when a finger is present.

Parameters:
- CNT_W, 16: width of the charge counter, threshold and reported cycle count.
- BASE_DELAY, 100: charge cycles from release to logic-high with no touch.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- drive_out  in  1  pad value driven by the sensor (its cap_out)
- drive_oe  in  1  sensor output enable; 1 = sensor drives the pad, 0 = pad floats and charges
- touch  in  1  emulated finger present
- touch_extra  in  CNT_W  extra charge cycles added while touched
- pad_level  out  1  pad logic level returned to the sensor (its cap_in)
- charge_done  out  1  one-cycle pulse when a floating pad crosses logic-high
- charge_cycles  out  CNT_W  length of the last completed charge, in cycles
- pad_state  out  2  current state, for debug

Behaviour:
- States: DRIVE_LO=0, CHARGING=1, CHARGED=2, DRIVE_HI=3.
- Reset values: state DRIVE_LO, counter 0, threshold 0, pad_level 0, charge_done 0, charge_cycles 0. The asynchronous reset is honoured in any state, including mid-charge.
- All outputs are registered. charge_done defaults to 0 on every edge unless set below.
- drive_oe=1 has absolute priority on every edge:
  - drive_out=0: go to DRIVE_LO, clear the counter, pad_level=0.
  - drive_out=1: go to DRIVE_HI, pad_level=1.
- DRIVE_LO with drive_oe=0 at the edge:
  - Go to CHARGING, counter=1, pad_level stays 0.
  - Latch threshold = BASE_DELAY + (touch ? touch_extra : 0). Compute at CNT_W+1 bits and saturate to 2^CNT_W-1. A result of 0 is forced to 1.
- CHARGING with drive_oe=0:
  - If counter == threshold: go to CHARGED, pad_level=1, charge_done=1, charge_cycles=counter.
  - Otherwise increment the counter, saturating at 2^CNT_W-1.
  - The threshold comparison uses the pre-increment counter value.
- Latency: pad_level rises on the threshold-th rising edge counted from the edge that first sampled drive_oe=0 in DRIVE_LO, plus one. With threshold=T, pad_level is high T+1 edges after release.
- touch and touch_extra are sampled only at the release edge. Changes mid-charge have no effect until the next charge.
- CHARGED with drive_oe=0: hold, pad_level=1.
- DRIVE_HI with drive_oe=0: go to CHARGED, pad_level stays 1. No charge_done, charge_cycles unchanged (the pad was already charged).
- Abort: drive_oe=1 during CHARGING gives no charge_done, charge_cycles keeps its previous value, and the counter is cleared.
- Simultaneous completion and drive: if the counter equals the threshold on the same edge that drive_oe=1, drive wins and there is no pulse.
- charge_done is never asserted on two consecutive cycles.

Optional Feature:
- Macro: CAP_PAD_MODEL_NOISE_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded to 8'hA5 on reset and advances every cycle.
  - At the release edge, the latched threshold additionally adds lfsr[1:0] (0..3 cycles), still with saturation.
  - Models measurement jitter, so the sensor's filtering can be exercised.
- Undefined: no LFSR logic, and the threshold is exactly as specified above, fully deterministic.

Test Plan:
- Reset, then drive_oe=1/drive_out=0 for 5 cycles, then drive_oe=0 with touch=0 -> pad_level rises exactly 101 edges after release, charge_done pulses once, charge_cycles=100.
- Same sequence with touch=1 and touch_extra=60 -> charge_cycles=160 and the pad_level rise is delayed 60 cycles relative to the untouched case. Toggling touch mid-charge does not change the result.
- Release, then re-assert drive_oe=1/drive_out=0 after 40 cycles -> no charge_done, pad_level stays 0, charge_cycles keeps its prior value, state=DRIVE_LO.
- drive_oe=1/drive_out=1, then release -> pad_level stays 1, state=CHARGED, no charge_done.
- touch_extra=16'hFFFF with touch=1 -> threshold saturates at 65535, charge_cycles=65535. Also: assert reset mid-charge -> all outputs return to reset values immediately.
- With CAP_PAD_MODEL_NOISE_EN defined, 50 charges with touch=0 -> every charge_cycles value is in 100..103 and at least two distinct values appear. Without the macro, all 50 values are 100.
